// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, parity modes and frame-length helper for the UART blocks
package uart_pkg;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, GAP = 3'd5;
  localparam int PARITY_NONE = 0, PARITY_EVEN = 1, PARITY_ODD = 2;
  function automatic int frame_bits(input int parity_mode, input int stop_bits);
    return 9 + (parity_mode != PARITY_NONE ? 1 : 0) + stop_bits;
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter with clear and a one-cycle terminal-count tick
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 432
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt;
  assign tick = !clr && cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else cnt <= cnt + CW'(1);
endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: serializes one accepted word as back-to-back UART frames, octet 0 first, LSB first
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 432,
  parameter int WORD_BYTES   = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_MODE  = 0,
  parameter int GAP_BITS     = 1
) (
  input  logic                          CLK_IN,
  input  logic                          resetIn,
  input  logic [8*WORD_BYTES-1:0]       word_in,
  input  logic                          word_valid,
  output logic                          word_ready,
  output logic                          UART_TX,
  output logic                          busy,
  output logic                          word_done,
  output logic [$clog2(WORD_BYTES):0]   byte_idx
);
  localparam int BW = $clog2(WORD_BYTES) + 1;
  localparam logic HAS_PAR = PARITY_MODE != PARITY_NONE;
  localparam logic ODD = PARITY_MODE == PARITY_ODD;
  logic [2:0] state;
  logic [8*WORD_BYTES-1:0] sh;
  logic [3:0] cnt;
  logic [BW-1:0] idx;
  logic par, tx, done, tick, last;
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) timer (
    .clk(CLK_IN), .rst(resetIn), .clr(state == IDLE), .tick(tick)
  );
  assign word_ready = state == IDLE;
  assign busy = !word_ready;
  assign UART_TX = tx;
  assign word_done = done;
  assign byte_idx = idx;
  assign last = idx == BW'(WORD_BYTES - 1);
  // the shift register moves one bit per data bit, so the next octet lands in sh[7:0]
  always_ff @(posedge CLK_IN or posedge resetIn)
    if (resetIn) begin
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
      idx <= '0;
      par <= 1'b0;
      tx <= 1'b1;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (word_valid) begin
          sh <= word_in;
          idx <= '0;
          par <= 1'b0;
          cnt <= '0;
          tx <= 1'b0;
          state <= START;
        end
        START: if (tick) begin
          state <= DATA;
          tx <= sh[0];
        end
        DATA: if (tick) begin
          sh <= sh >> 1;
          par <= par ^ sh[0];
          if (cnt == 4'd7) begin
            cnt <= '0;
            state <= HAS_PAR ? PARITY : STOP;
            tx <= HAS_PAR ? par ^ sh[0] ^ ODD : 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
            tx <= sh[1];
          end
        end
        PARITY: if (tick) begin
          state <= STOP;
          tx <= 1'b1;
        end
        STOP: if (tick) begin
          if (cnt == 4'(STOP_BITS - 1)) begin
            cnt <= '0;
            if (!last) begin
              state <= START;
              idx <= idx + BW'(1);
              par <= 1'b0;
              tx <= 1'b0;
            end else if (GAP_BITS > 0) state <= GAP;
            else begin
              state <= IDLE;
              done <= 1'b1;
            end
          end else cnt <= cnt + 4'd1;
        end
        GAP: if (tick) begin
          if (cnt == 4'(GAP_BITS - 1)) begin
            cnt <= '0;
            state <= IDLE;
            done <= 1'b1;
          end else cnt <= cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: random words checked cycle-by-cycle against a bit-queue model of the serial line
module tb_uart_word_tx;
  import uart_pkg::*;
  localparam int CPB = 4, WB = 8, SB = 2, PM = PARITY_EVEN, GB = 2;
  localparam int W = 8 * WB, BW = $clog2(WB) + 1;
  localparam int FB = frame_bits(PM, SB);
  logic clk = 1'b0, rst = 1'b1, word_valid = 1'b0;
  logic [W-1:0] word_in = '0;
  logic word_ready, uart_tx, busy, word_done;
  logic [BW-1:0] byte_idx;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  uart_word_tx #(
    .CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .STOP_BITS(SB), .PARITY_MODE(PM), .GAP_BITS(GB)
  ) dut (
    .CLK_IN(clk), .resetIn(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .UART_TX(uart_tx), .busy(busy), .word_done(word_done),
    .byte_idx(byte_idx)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick1();
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_tx"}, uart_tx, 1);
    check({tag, "_ready"}, word_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, word_done, 0);
  endtask
  task automatic accept(input logic [W-1:0] w);
    word_in = w;
    word_valid = 1'b1;
    for (int t = 0; t < 20 && !word_ready; t++) tick1();
    check("ready_wait", word_ready, 1);
    tick1();
  endtask
  // called one cycle after acceptance; returns on the cycle word_done is high
  task automatic run_word(input logic [W-1:0] w, input logic nv, input logic [W-1:0] nw);
    bit q[$];
    logic [7:0] o;
    int len;
    word_valid = nv;
    word_in = nw;
    for (int b = 0; b < WB; b++) begin
      o = w[8*b +: 8];
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(o[i]);
      if (PM != PARITY_NONE) q.push_back(^o ^ (PM == PARITY_ODD));
      repeat (SB) q.push_back(1'b1);
    end
    repeat (GB) q.push_back(1'b1);
    len = q.size() * CPB;
    for (int k = 0; k < len; k++) begin
      check("tx", uart_tx, q[k / CPB]);
      check("busy", busy, 1);
      check("ready", word_ready, 0);
      check("done", word_done, 0);
      if (k < WB * FB * CPB) check("byte_idx", byte_idx, k / (FB * CPB));
      tick1();
    end
    check("done_end", word_done, 1);
    check("ready_end", word_ready, 1);
    check("busy_end", busy, 0);
    check("tx_end", uart_tx, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [W-1:0] words [5];
    logic [W-1:0] w;
    repeat (10) tick1();
    check_idle("rst");
    check("rst_idx", byte_idx, 0);
    rst = 1'b0;
    repeat (3) tick1();
    check_idle("post_rst");
    accept(64'hFF00_FF00_FF00_FF00);
    run_word(64'hFF00_FF00_FF00_FF00, 1'b0, '0);
    tick1();
    check_idle("after_fixed");
    words[0] = 64'h1234_5678_9ABC_0307;
    for (int i = 1; i < 5; i++) words[i] = {$urandom, $urandom};
    accept(words[0]);
    for (int i = 0; i < 5; i++) begin
      run_word(words[i], i < 4, i < 4 ? words[i + 1] : {$urandom, $urandom});
      if (i < 4) tick1();
    end
    word_valid = 1'b0;
    tick1();
    check_idle("after_b2b");
    w = {$urandom, $urandom} & ~(64'hFF << 40);
    accept(w);
    word_valid = 1'b0;
    repeat (5 * FB * CPB + 3 * CPB + 1) tick1();
    check("pre_rst_busy", busy, 1);
    check("pre_rst_tx", uart_tx, 0);
    check("pre_rst_idx", byte_idx, 5);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_tx", uart_tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", word_ready, 1);
    check("mid_rst_idx", byte_idx, 0);
    repeat (3) tick1();
    rst = 1'b0;
    for (int i = 0; i < 2 * CPB; i++) begin
      tick1();
      check_idle("no_resume");
    end
    w = {$urandom, $urandom};
    accept(w);
    run_word(w, 1'b0, '0);
    tick1();
    check_idle("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
Parametrised UART word serializer. It accepts one WORD_BYTES-wide word through a valid/ready handshake and transmits it as WORD_BYTES consecutive 8-bit UART frames: octet 0 first, each octet LSB first. Optional parity, configurable stop bits and an inter-word gap are supported. It sits on the host-link side of the multiplier top, driving operand/result words over UART_TX. It also serves as a synthesizable stimulus source for system benches.

Parameters:
CLKS_PER_BIT, 432, clock cycles per UART bit (≥2)
WORD_BYTES, 16, octets per word (1..32)
STOP_BITS, 1, stop bits per frame (1 or 2)
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
GAP_BITS, 1, idle-high bit times after the last frame of a word (0..15)

Ports:
CLK_IN  in  1  system clock; single clock domain
resetIn  in  1  asynchronous, active-high reset
word_in  in  8*WORD_BYTES  word to send; octet k = word_in[8k+7:8k]
word_valid  in  1  word_in is valid
word_ready  out  1  block can accept a word this cycle
UART_TX  out  1  serial line; idle high
busy  out  1  high from acceptance until the gap has finished
word_done  out  1  one-cycle pulse when the word, including the gap, is complete
byte_idx  out  $clog2(WORD_BYTES)+1  index of the octet currently on the line

Behaviour:
- Reset (async, resetIn=1): state IDLE; UART_TX=1; word_ready=1; busy=0; word_done=0; byte_idx=0; counters cleared; shift register cleared. Reset mid-frame truncates the frame immediately. The line is held high, and no partial frame resumes after release.
- Handshake: transfer occurs on a rising edge with word_valid && word_ready.
  - word_in is captured into an internal register on that edge.
  - word_ready=1 only in IDLE; it is 0 in every other state, including GAP.
  - word_valid while not ready is ignored and is not queued.
- States: IDLE → START → DATA → [PARITY] → STOP → (next octet: START | last octet: GAP) → IDLE.
- Timing:
  - START is entered on the cycle after acceptance.
  - Every bit (start, data, parity, stop, gap) holds UART_TX for exactly CLKS_PER_BIT cycles.
  - A bit counter runs 0..CLKS_PER_BIT-1 and advances the state or bit index at terminal count.
- Line values: START drives 0. DATA drives bits 0..7 of the current octet, LSB first. STOP drives 1 for STOP_BITS bit times. GAP drives 1 for GAP_BITS bit times.
- Parity: with PARITY_MODE=1, the parity bit is the XOR of the 8 data bits. With PARITY_MODE=2, it is the inverted XOR. With PARITY_MODE=0, the PARITY state is skipped with no extra cycles.
- Octets go out back to back with no idle between frames within a word. byte_idx increments at the STOP→START transition.
- If GAP_BITS=0, STOP of the last octet goes directly to IDLE.
- word_done pulses on the same edge that returns the state to IDLE. word_ready is 1 from the following cycle.
- A new word may be accepted on the first IDLE cycle. Minimum inter-word idle is therefore 1 clock plus the GAP time.
- Word duration, acceptance to word_done: WORD_BYTES*(1+8+P+STOP_BITS)*CLKS_PER_BIT + GAP_BITS*CLKS_PER_BIT cycles, where P=1 if parity is enabled.
- UART_TX is driven from a register, so it is glitch-free.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams (IDLE, START, DATA, PARITY, STOP, GAP);
  - PARITY_NONE / PARITY_EVEN / PARITY_ODD constants;
  - the frame-length function (bits per frame from PARITY_MODE and STOP_BITS).
- One sub-module, uart_bit_timer: CLKS_PER_BIT counter with clear input and a one-cycle tick output at terminal count. It is reusable by the matching receiver.

Test Plan:
1. Reset: hold resetIn=1 for 10 cycles → UART_TX=1, word_ready=1, busy=0, byte_idx=0. Then release.
2. Defaults, word_in=128'hFF00FF00FF00FF00FF00FF00FF00FF00:
   - Line carries 16 frames. Octet 0 is start, 0x00 LSB first, stop; octet 1 is 0xFF.
   - Each bit is exactly 432 cycles.
   - word_done arrives 16*10*432+432 = 69552 cycles after acceptance.
3. WORD_BYTES=2, PARITY_MODE=1, STOP_BITS=2, CLKS_PER_BIT=4, word_in=16'h0307:
   - Octet 0x07 has parity 1; octet 0x03 has parity 0.
   - Frame is 12 bits; word_done 2*12*4+4 = 100 cycles after acceptance.
4. Back-to-back: keep word_valid=1 with two words → second accepted exactly 1 cycle after the first word_done. word_ready=0 throughout the gap.
5. Assert resetIn mid-DATA of octet 5 → UART_TX=1 asynchronously and busy=0. After release, a new word starts cleanly from octet 0.
6. Assert word_valid while busy with a different word_in → ignored. The transmitted octets match only the originally captured word.
